// File: rtl/pmod_i2c_pkg.sv
// Shared types and constants for the PMOD I2C target.
package pmod_i2c_pkg;

    // Target protocol states.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } target_state_t;

    // Value of the R/W bit in the address byte.
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    // Bit counter must reach 9 (8 data bits plus the ACK slot).
    localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/pmod_i2c_line_sync.sv
// Synchronises the raw SCL/SDA pins and derives edge and START/STOP events.
module pmod_i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    // Bit 0 carries SCL, bit 1 carries SDA.
    logic [1:0] raw_line;
    logic [1:0] sync_line;
    logic [1:0] dly_line;

    assign raw_line = {sda_i, scl_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic meta_reg;
            logic sync_reg;
            logic dly_reg;

            // Two-flop synchroniser plus one delay flop; idle bus level is high.
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    dly_reg  <= 1'b1;
                end else begin
                    meta_reg <= raw_line[gi];
                    sync_reg <= meta_reg;
                    dly_reg  <= sync_reg;
                end
            end

            assign sync_line[gi] = sync_reg;
            assign dly_line[gi]  = dly_reg;
        end
    endgenerate

    // SDA transitions are only START/STOP when SCL is stable high.
    assign scl_rise = sync_line[0] & ~dly_line[0];
    assign scl_fall = ~sync_line[0] & dly_line[0];
    assign start    = sync_line[0] & dly_line[0] & dly_line[1] & ~sync_line[1];
    assign stop     = sync_line[0] & dly_line[0] & ~dly_line[1] & sync_line[1];
    assign sda_s    = sync_line[1];

endmodule

// File: rtl/pmod_i2c_target.sv
// I2C target exposing an 8-bit pointer-addressed register bus (EEPROM-style framing).
module pmod_i2c_target
    import pmod_i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda_s;

    pmod_i2c_line_sync u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    target_state_t        state_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [7:0]           shift_reg;
    logic [7:0]           ptr_reg;
    logic                 rw_reg;
    logic                 cap_reg;
    logic                 sda_oe_reg;
    logic                 busy_reg;
    logic [7:0]           reg_addr_reg;
    logic [7:0]           reg_wdata_reg;
    logic                 reg_we_reg;
    logic                 reg_re_reg;

    logic [7:0] rx_byte;
    logic       rx_last;

    // Byte as it will look once the bit arriving on this SCL rise is shifted in.
    always_comb begin
        rx_byte = {shift_reg[6:0], sda_s};
        rx_last = scl_rise && (bit_cnt_reg == BIT_CNT_W'(7));
    end

    // Protocol FSM: bit reception, ACK slots, register strobes and read shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            ptr_reg       <= '0;
            rw_reg        <= I2C_RW_WRITE;
            cap_reg       <= 1'b0;
            sda_oe_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            reg_addr_reg  <= '0;
            reg_wdata_reg <= '0;
            reg_we_reg    <= 1'b0;
            reg_re_reg    <= 1'b0;
        end else begin
            reg_we_reg <= 1'b0;
            reg_re_reg <= 1'b0;
            // Read data is valid the cycle after the strobe, so capture one cycle later.
            cap_reg    <= reg_re_reg;

            if (start) begin
                state_reg   <= ST_ADDR;
                bit_cnt_reg <= '0;
                sda_oe_reg  <= 1'b0;
                busy_reg    <= 1'b0;
                cap_reg     <= 1'b0;
            end else if (stop) begin
                state_reg  <= ST_IDLE;
                sda_oe_reg <= 1'b0;
                busy_reg   <= 1'b0;
                cap_reg    <= 1'b0;
            end else begin
                if (scl_rise) begin
                    bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
                end

                case (state_reg)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                        end
                        if (rx_last) begin
                            if (rx_byte[7:1] == I2C_ADDR) begin
                                rw_reg    <= rx_byte[0];
                                state_reg <= ST_ADDR_ACK;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        // First fall opens the ACK slot, second fall closes it.
                        if (scl_fall) begin
                            if (!sda_oe_reg) begin
                                sda_oe_reg <= 1'b1;
                                busy_reg   <= 1'b1;
                            end else begin
                                sda_oe_reg  <= 1'b0;
                                bit_cnt_reg <= '0;
                                if (rw_reg == I2C_RW_READ) begin
                                    state_reg    <= ST_RDATA;
                                    reg_re_reg   <= 1'b1;
                                    reg_addr_reg <= ptr_reg;
                                end else begin
                                    state_reg <= ST_PTR;
                                end
                            end
                        end
                    end

                    ST_PTR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                        end
                        if (rx_last) begin
                            ptr_reg   <= rx_byte;
                            state_reg <= ST_PTR_ACK;
                        end
                    end

                    ST_WDATA: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                        end
                        if (rx_last) begin
                            reg_we_reg    <= 1'b1;
                            reg_addr_reg  <= ptr_reg;
                            reg_wdata_reg <= rx_byte;
                            ptr_reg       <= ptr_reg + 8'd1;
                            state_reg     <= ST_WDATA_ACK;
                        end
                    end

                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_reg) begin
                                sda_oe_reg <= 1'b1;
                            end else begin
                                sda_oe_reg  <= 1'b0;
                                bit_cnt_reg <= '0;
                                state_reg   <= ST_WDATA;
                            end
                        end
                    end

                    ST_RDATA: begin
                        if (cap_reg) begin
                            shift_reg  <= reg_rdata;
                            ptr_reg    <= ptr_reg + 8'd1;
                            sda_oe_reg <= ~reg_rdata[7];
                        end else if (scl_fall && (bit_cnt_reg != '0)) begin
                            if (bit_cnt_reg == BIT_CNT_W'(8)) begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= ST_RDATA_ACK;
                            end else begin
                                sda_oe_reg <= ~shift_reg[6];
                                shift_reg  <= {shift_reg[6:0], 1'b0};
                            end
                        end
                    end

                    ST_RDATA_ACK: begin
                        // A NACK ends the read at once; a fall here means the host ACKed.
                        if (scl_rise && sda_s) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end else if (scl_fall) begin
                            reg_re_reg   <= 1'b1;
                            reg_addr_reg <= ptr_reg;
                            bit_cnt_reg  <= '0;
                            state_reg    <= ST_RDATA;
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_reg;
    assign busy      = busy_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign reg_we    = reg_we_reg;
    assign reg_re    = reg_re_reg;

endmodule

// File: tb/tb_pmod_i2c_target.sv
// Directed bench for pmod_i2c_target: bit-banged I2C host plus register-file model.
module tb_pmod_i2c_target;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    wire        sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    int total = 0;
    int bad = 0;

    logic [15:0] we_q[$];
    logic [7:0]  re_q[$];
    logic        oe_seen = 1'b0;
    logic        busy_seen = 1'b0;

    logic       ack_n;
    logic [7:0] rd;

    // Open-drain bus: either side can pull low.
    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    pmod_i2c_target #(.I2C_ADDR(7'h28)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register-file model: read data is ~address, valid the cycle after reg_re.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= ~reg_addr;
    end

    // Strobe and line monitor.
    always @(negedge clk) begin
        if (reg_we) begin
            we_q.push_back({reg_addr, reg_wdata});
            $display("[%0t] reg_we addr=%02h data=%02h", $time, reg_addr, reg_wdata);
        end
        if (reg_re) begin
            re_q.push_back(reg_addr);
            $display("[%0t] reg_re addr=%02h", $time, reg_addr);
        end
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clear_logs();
        we_q.delete();
        re_q.delete();
        oe_seen = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
        $display("[%0t] START", $time);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        $display("[%0t] STOP", $time);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic nack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        nack = sda_bus; wait_q();
        scl_m = 1'b0; wait_q();
        $display("[%0t] host wrote %02h ack_n=%0b", $time, b, nack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_q();
            scl_m = 1'b1; wait_q();
            d[i] = sda_bus; wait_q();
            scl_m = 1'b0; wait_q();
        end
        sda_m = nack; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
        $display("[%0t] host read %02h ack_n=%0b", $time, d, nack);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sda_oe", 16'(sda_oe), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_we", 16'(reg_we), 16'h0);
        check("rst_re", 16'(reg_re), 16'h0);
        check("rst_addr", 16'(reg_addr), 16'h00);
        check("rst_wdata", 16'(reg_wdata), 16'h00);
        wait_q();

        // Write: 0x50, ptr 0x03, 0xAA, 0x55
        clear_logs();
        i2c_start();
        write_byte(8'h50, ack_n); check("wr_addr_ack", 16'(ack_n), 16'h0);
        check("wr_busy", 16'(busy), 16'h1);
        write_byte(8'h03, ack_n); check("wr_ptr_ack", 16'(ack_n), 16'h0);
        write_byte(8'hAA, ack_n); check("wr_d0_ack", 16'(ack_n), 16'h0);
        write_byte(8'h55, ack_n); check("wr_d1_ack", 16'(ack_n), 16'h0);
        i2c_stop();
        check("wr_busy_stop", 16'(busy), 16'h0);
        check("wr_we_cnt", 16'(we_q.size()), 16'd2);
        check("wr_we0", (we_q.size() > 0) ? we_q[0] : 16'hxxxx, 16'h03AA);
        check("wr_we1", (we_q.size() > 1) ? we_q[1] : 16'hxxxx, 16'h0455);
        check("wr_re_cnt", 16'(re_q.size()), 16'd0);

        // Wrong address: 0x30 (0x18) must be ignored
        clear_logs();
        i2c_start();
        write_byte(8'h30, ack_n); check("na_addr_nack", 16'(ack_n), 16'h1);
        write_byte(8'h12, ack_n); check("na_data_nack", 16'(ack_n), 16'h1);
        i2c_stop();
        check("na_oe_seen", 16'(oe_seen), 16'h0);
        check("na_busy_seen", 16'(busy_seen), 16'h0);
        check("na_we_cnt", 16'(we_q.size()), 16'd0);
        check("na_re_cnt", 16'(re_q.size()), 16'd0);

        // Random read from 0x07, two bytes
        clear_logs();
        i2c_start();
        write_byte(8'h50, ack_n); check("rr_addr_ack", 16'(ack_n), 16'h0);
        write_byte(8'h07, ack_n); check("rr_ptr_ack", 16'(ack_n), 16'h0);
        i2c_start();
        write_byte(8'h51, ack_n); check("rr_raddr_ack", 16'(ack_n), 16'h0);
        read_byte(1'b0, rd); check("rr_byte0", 16'(rd), 16'h00F8);
        read_byte(1'b1, rd); check("rr_byte1", 16'(rd), 16'h00F7);
        check("rr_oe_after_nack", 16'(sda_oe), 16'h0);
        check("rr_busy_after_nack", 16'(busy), 16'h0);
        i2c_stop();
        check("rr_re_cnt", 16'(re_q.size()), 16'd2);
        check("rr_re0", (re_q.size() > 0) ? 16'(re_q[0]) : 16'hxxxx, 16'h07);
        check("rr_re1", (re_q.size() > 1) ? 16'(re_q[1]) : 16'hxxxx, 16'h08);
        check("rr_we_cnt", 16'(we_q.size()), 16'd0);

        // Pointer wrap, then a read that continues from the wrapped pointer
        clear_logs();
        i2c_start();
        write_byte(8'h50, ack_n);
        write_byte(8'hFF, ack_n);
        write_byte(8'h11, ack_n); check("wp_d0_ack", 16'(ack_n), 16'h0);
        write_byte(8'h22, ack_n); check("wp_d1_ack", 16'(ack_n), 16'h0);
        i2c_stop();
        check("wp_we0", (we_q.size() > 0) ? we_q[0] : 16'hxxxx, 16'hFF11);
        check("wp_we1", (we_q.size() > 1) ? we_q[1] : 16'hxxxx, 16'h0022);
        i2c_start();
        write_byte(8'h51, ack_n); check("wp_raddr_ack", 16'(ack_n), 16'h0);
        read_byte(1'b1, rd); check("wp_rd", 16'(rd), 16'h00FE);
        i2c_stop();
        check("wp_re_cnt", 16'(re_q.size()), 16'd1);
        check("wp_re0", (re_q.size() > 0) ? 16'(re_q[0]) : 16'hxxxx, 16'h01);

        // STOP after 4 bits of a data byte
        clear_logs();
        i2c_start();
        write_byte(8'h50, ack_n);
        write_byte(8'h20, ack_n);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        check("ab_busy", 16'(busy), 16'h0);
        check("ab_we_cnt", 16'(we_q.size()), 16'd0);
        i2c_start();
        write_byte(8'h50, ack_n); check("ab_next_ack", 16'(ack_n), 16'h0);
        write_byte(8'h30, ack_n);
        write_byte(8'h5A, ack_n); check("ab_next_d_ack", 16'(ack_n), 16'h0);
        i2c_stop();
        check("ab_we_cnt2", 16'(we_q.size()), 16'd1);
        check("ab_we0", (we_q.size() > 0) ? we_q[0] : 16'hxxxx, 16'h305A);

        // Reset while the target is pulling SDA low mid-read (data 0x7F, bit7=0)
        i2c_start();
        write_byte(8'h50, ack_n);
        write_byte(8'h80, ack_n);
        i2c_start();
        write_byte(8'h51, ack_n); check("mr_raddr_ack", 16'(ack_n), 16'h0);
        check("mr_oe_before", 16'(sda_oe), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_oe_next", 16'(sda_oe), 16'h0);
        check("mr_busy_next", 16'(busy), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b1);
        scl_m = 1'b1; wait_q();
        check("mr_no_oe", 16'(oe_seen), 16'h0);
        check("mr_no_we", 16'(we_q.size()), 16'd0);
        check("mr_no_re", 16'(re_q.size()), 16'd0);
        i2c_start();
        write_byte(8'h51, ack_n); check("mr_new_ack", 16'(ack_n), 16'h0);
        read_byte(1'b1, rd); check("mr_ptr0_data", 16'(rd), 16'h00FF);
        i2c_stop();
        check("mr_re0", (re_q.size() > 0) ? 16'(re_q[0]) : 16'hxxxx, 16'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmod_i2c_target.md
Name: pmod_i2c_target

Overview:
Byte-level I2C target (responder) that exposes an 8-bit-addressed register bus to an external I2C host, such as a test MCU or a second board on the PMOD I2C lines. It is the responder-side counterpart of our I2C initiator drivers and follows the same open-drain convention (oe=1 pulls the line low). It uses EEPROM/PCA9557-style framing: a pointer byte, then auto-incrementing data bytes. It sits between the PMOD SCL/SDA pins and a user register file.

Parameters:
I2C_ADDR, 7'h28, 7-bit target address; must not clash with the codec, EEPROM, LED or GPIO devices on the bus.

Ports:
clk  in  1  system clock; at least 16x the SCL frequency
rst  in  1  synchronous, active-high reset
scl_i  in  1  raw SCL pin level
sda_i  in  1  raw SDA pin level
sda_oe  out  1  1 = pull SDA low
reg_addr  out  8  register address for the current access
reg_wdata  out  8  write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid the cycle after reg_re
busy  out  1  1 while addressed, from address ACK until STOP, START or NACK

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: sda_oe, reg_we, reg_re, busy = 0; reg_addr, reg_wdata = 0; pointer = 0; state = IDLE; synchronizer flops = 1.
- Input conditioning:
  - 2-FF synchronizer on scl_i and sda_i, plus one delay flop for edge detection.
  - START = synced SDA falls while SCL high. STOP = synced SDA rises while SCL high.
  - SCL rise and fall are detected as single-cycle events.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- Global events:
  - START in any state: go to ADDR, clear the bit counter, release SDA.
  - STOP in any state: go to IDLE, release SDA, busy = 0.
  - START/STOP take priority over any same-cycle SCL edge.
- Bit sampling: on SCL rise, shift synced SDA into the byte register, MSB first. The 8th rise completes the byte.
- SDA timing: sda_oe changes only in the cycle after a detected SCL fall (hold time). An ACK is driven on the fall after the 8th bit and released on the fall that ends the ACK slot.
- ADDR:
  - byte[7:1] == I2C_ADDR: ACK and set busy.
    - R/W = 0: go to PTR.
    - R/W = 1: go to RDATA.
  - Mismatch: no ACK, go to IDLE (ignore the bus until the next START).
- PTR: the first written byte loads the pointer. ACK it; no reg_we. Go to WDATA.
- WDATA: in the cycle after the 8th rise, issue reg_we with reg_addr = pointer and reg_wdata = byte, and increment the pointer. ACK every byte.
- RDATA:
  - Fetch on the SCL fall ending the address-ACK or a master-ACK slot: reg_re = 1 with reg_addr = pointer.
  - Next cycle: capture reg_rdata, increment the pointer, drive sda_oe = ~bit7.
  - Drive each remaining bit on successive SCL falls.
  - After the 8th bit, release SDA and sample the master ACK on the 9th rise.
    - ACK (SDA low): fetch the next byte.
    - NACK: go to IDLE, busy = 0, no further fetch.
- Pointer: 8-bit, wraps 0xFF -> 0x00. It persists across transactions, so a read with no pointer write continues from the last pointer.
- Repeated START after a PTR write enables a random read.
- Reset mid-transaction: sda_oe = 0 on the next cycle, and no strobes are issued.
- Never drives SCL; clock stretching is unsupported.

Decomposition:
- Package pmod_i2c_pkg:
  - target state enum
  - I2C_RW_READ/I2C_RW_WRITE constants
  - bit-count width constant
- Sub-module pmod_i2c_line_sync: synchronizers, edge detect and START/STOP detect. Outputs scl_rise, scl_fall, start, stop, sda_s.

Test Plan:
- Write: START, 0x50, 0x03, 0xAA, 0x55, STOP -> four ACKs (SDA low in each 9th slot); reg_we (3, 0xAA) then (4, 0x55); busy falls at STOP.
- Wrong address: START, 0x30, 0x12, STOP -> SDA never pulled low; no reg_we or reg_re; busy stays 0.
- Random read: START, 0x50, 0x07, repeated START, 0x51, read 2 bytes (ACK, then NACK), with bench model rdata = ~addr -> bytes 0xF8, 0xF7; reg_re at 7, 8, not 9; SDA released after NACK.
- Wrap: pointer 0xFF, write 0x11, 0x22 -> reg_we at 0xFF then 0x00; a following read with no pointer write returns the value for addr 0x01.
- STOP after 4 bits of a WDATA byte -> IDLE, no reg_we, busy = 0; the next transaction works normally.
- rst asserted while sda_oe = 1 mid-read -> sda_oe = 0 the next cycle, pointer = 0, no strobes until a new START.
